// File: rtl/alu_if_pkg.sv
// Shared definitions for the serial ALU interface: word layout, command codes,
// transmitter FSM states and the word-building helpers.
package alu_if_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned WORD_W   = DATA_W + 2;
   localparam int unsigned MAX_ARGS = 10;

   localparam logic FLAG_DATA = 1'b0;
   localparam logic FLAG_CMD  = 1'b1;

   localparam logic [DATA_W-1:0] CMD_NOP = 8'h00;
   localparam logic [DATA_W-1:0] CMD_AND = 8'h01;
   localparam logic [DATA_W-1:0] CMD_OR  = 8'h02;
   localparam logic [DATA_W-1:0] CMD_XOR = 8'h03;
   localparam logic [DATA_W-1:0] CMD_ADD = 8'h10;
   localparam logic [DATA_W-1:0] CMD_SUB = 8'h20;
   localparam logic [DATA_W-1:0] CMD_INV = 8'h80;
   localparam logic [DATA_W-1:0] CMD_RST = 8'hFF;

   typedef enum logic [2:0] {StIdle, StStart, StBits, StStop, StGap} tx_state_t;

   function automatic logic even_parity(input logic flag, input logic [DATA_W-1:0] payload);
      return ^{flag, payload};
   endfunction

   // {flag, payload, p}; bad inverts p so the receiver sees a parity error.
   function automatic logic [WORD_W-1:0] make_word(input logic              flag,
                                                   input logic [DATA_W-1:0] payload,
                                                   input logic              bad);
      return {flag, payload, even_parity(flag, payload) ^ bad};
   endfunction

endpackage

// File: rtl/alu_word_tx.sv
// Serialises one word: start bit 0, WORD_W bits MSB first, stop bit 1.
// A new load on the stop cycle chains words with no idle gap.
module alu_word_tx
   import alu_if_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   output logic              sout_o,
   output logic              word_last_o
);

   logic [WORD_W:0] sh_q;
   logic [3:0]      cnt_q;
   logic            active_q;
   logic            sout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sout_q   <= 1'b1;
         sh_q     <= '1;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (load_i) begin
         sout_q   <= 1'b0;
         sh_q     <= {word_i, 1'b1};
         cnt_q    <= 4'(WORD_W + 1);
         active_q <= 1'b1;
      end else if (active_q && cnt_q != 4'd0) begin
         sout_q <= sh_q[WORD_W];
         sh_q   <= {sh_q[WORD_W-1:0], 1'b1};
         cnt_q  <= cnt_q - 4'd1;
      end else begin
         sout_q   <= 1'b1;
         active_q <= 1'b0;
      end
   end

   assign sout_o      = sout_q;
   assign word_last_o = active_q && (cnt_q == 4'd0);

endmodule

// File: rtl/alu_frame_tx.sv
// Request-driven frame transmitter for the serial ALU: latches a request, sends
// its argument words then the command word, followed by an idle gap.
module alu_frame_tx
   import alu_if_pkg::*;
#(
   parameter int unsigned IDLE_GAP = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [DATA_W-1:0]          req_cmd,
   input  logic [3:0]                 req_arg_num,
   input  logic [MAX_ARGS*DATA_W-1:0] req_data,
   input  logic                       req_bad_parity,
   output logic                       sout,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       err_arg
);

   tx_state_t         state_q;
   logic [3:0]        bit_cnt_q;
   logic [3:0]        word_idx_q;
   logic [3:0]        n_q;
   logic [DATA_W-1:0] cmd_q;
   logic [DATA_W-1:0] args_q [MAX_ARGS];
   logic              bad_q;
   logic [7:0]        gap_cnt_q;
   logic              busy_q;
   logic              frame_done_q;
   logic              err_arg_q;

   logic              accept;
   logic              arg_ok;
   logic              last_word;
   logic              load;
   logic              word_last;
   logic [3:0]        next_idx;
   logic [WORD_W-1:0] load_word;

   assign req_ready = (state_q == StIdle) && !rst;
   assign accept    = req_valid && req_ready;
   assign arg_ok    = req_arg_num <= 4'(MAX_ARGS);
   assign next_idx  = word_idx_q + 4'd1;
   assign last_word = (word_idx_q == n_q);

   // The first word comes straight from the request so it can start on the accept edge.
   always_comb begin
      load      = 1'b0;
      load_word = '0;
      if (state_q == StIdle) begin
         load      = accept && arg_ok;
         load_word = (req_arg_num == 4'd0) ? make_word(FLAG_CMD, req_cmd, req_bad_parity)
                                          : make_word(FLAG_DATA, req_data[DATA_W-1:0],
                                                      req_bad_parity);
      end else if (state_q == StStop && word_last && !last_word) begin
         load      = 1'b1;
         load_word = (next_idx == n_q) ? make_word(FLAG_CMD, cmd_q, bad_q)
                                       : make_word(FLAG_DATA, args_q[next_idx], bad_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         word_idx_q   <= '0;
         n_q          <= '0;
         cmd_q        <= '0;
         bad_q        <= 1'b0;
         gap_cnt_q    <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_arg_q    <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         err_arg_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (arg_ok) begin
                     n_q        <= req_arg_num;
                     cmd_q      <= req_cmd;
                     bad_q      <= req_bad_parity;
                     for (int i = 0; i < MAX_ARGS; i++) begin
                        args_q[i] <= req_data[i*DATA_W +: DATA_W];
                     end
                     word_idx_q <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= StStart;
                  end else begin
                     err_arg_q <= 1'b1;
                  end
               end
            end
            StStart: begin
               bit_cnt_q <= 4'd9;
               state_q   <= StBits;
            end
            StBits: begin
               if (bit_cnt_q == 4'd0) state_q <= StStop;
               else bit_cnt_q <= bit_cnt_q - 4'd1;
            end
            StStop: begin
               if (word_last) begin
                  if (!last_word) begin
                     word_idx_q <= next_idx;
                     state_q    <= StStart;
                  end else begin
                     busy_q       <= 1'b0;
                     frame_done_q <= 1'b1;
                     if (IDLE_GAP == 0) begin
                        state_q <= StIdle;
                     end else begin
                        gap_cnt_q <= 8'(IDLE_GAP - 1);
                        state_q   <= StGap;
                     end
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q == 8'd0) state_q <= StIdle;
               else gap_cnt_q <= gap_cnt_q - 8'd1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   alu_word_tx u_word_tx (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .word_i      (load_word),
      .sout_o      (sout),
      .word_last_o (word_last)
   );

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign err_arg    = err_arg_q;

endmodule

// File: tb/tb_alu_frame_tx.sv
// Self-checking bench for alu_frame_tx: directed and random requests compared
// cycle by cycle against an expected serial bit stream built from the word rules.
module tb_alu_frame_tx;

   localparam int unsigned IDLE_GAP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_cmd;
   logic [3:0]  req_arg_num;
   logic [79:0] req_data;
   logic        req_bad_parity;
   logic        sout;
   logic        busy;
   logic        frame_done;
   logic        err_arg;

   int n_total = 0;
   int n_bad   = 0;

   alu_frame_tx #(.IDLE_GAP(IDLE_GAP)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_cmd        (req_cmd),
      .req_arg_num    (req_arg_num),
      .req_data       (req_data),
      .req_bad_parity (req_bad_parity),
      .sout           (sout),
      .busy           (busy),
      .frame_done     (frame_done),
      .err_arg        (err_arg)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference bit for one word position, straight from the framing rules.
   task automatic push_word(inout bit q[$], input bit flag, input logic [7:0] pay, input bit bad);
      bit p;
      p = bit'(($countones({flag, pay}) % 2) == 1) ^ bad;
      q.push_back(1'b0);
      q.push_back(flag);
      for (int b = 7; b >= 0; b--) q.push_back(pay[b]);
      q.push_back(p);
      q.push_back(1'b1);
   endtask

   task automatic scramble_inputs();
      logic [95:0] r;
      r              = {$urandom(), $urandom(), $urandom()};
      req_data       = r[79:0];
      req_cmd        = 8'($urandom());
      req_arg_num    = 4'($urandom());
      req_bad_parity = 1'($urandom());
   endtask

   // Issue one request and check every cycle until ready returns. Starts/ends on a negedge.
   task automatic run_req(input logic [7:0] cmd, input int n, input logic [79:0] data,
                          input bit bad);
      bit q[$];
      int to;
      int total;
      int last;
      to = 0;
      while (req_ready !== 1'b1 && to < 300) begin
         @(negedge clk);
         to++;
      end
      check_eq("ready_before_req", 32'(req_ready), 1);
      req_cmd        = cmd;
      req_arg_num    = 4'(n);
      req_data       = data;
      req_bad_parity = bad;
      req_valid      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (n > 10) begin
         for (int k = 1; k <= 4; k++) begin
            check_eq($sformatf("err_arg k=%0d", k), 32'(err_arg), (k == 1) ? 1 : 0);
            check_eq($sformatf("err_sout k=%0d", k), 32'(sout), 1);
            check_eq($sformatf("err_busy k=%0d", k), 32'(busy), 0);
            check_eq($sformatf("err_ready k=%0d", k), 32'(req_ready), 1);
            check_eq($sformatf("err_done k=%0d", k), 32'(frame_done), 0);
            scramble_inputs();
            if (k < 4) @(negedge clk);
         end
         return;
      end
      for (int w = 0; w < n; w++) push_word(q, 1'b0, data[8*w +: 8], bad);
      push_word(q, 1'b1, cmd, bad);
      total = 12 * (n + 1);
      last  = total + 1 + IDLE_GAP;
      for (int k = 1; k <= last; k++) begin
         check_eq($sformatf("sout n=%0d k=%0d", n, k), 32'(sout), (k <= total) ? 32'(q[k-1]) : 1);
         check_eq($sformatf("busy n=%0d k=%0d", n, k), 32'(busy), (k <= total) ? 1 : 0);
         check_eq($sformatf("done n=%0d k=%0d", n, k), 32'(frame_done), (k == total + 1) ? 1 : 0);
         check_eq($sformatf("ready n=%0d k=%0d", n, k), 32'(req_ready), (k == last) ? 1 : 0);
         check_eq($sformatf("err n=%0d k=%0d", n, k), 32'(err_arg), 0);
         scramble_inputs();
         if (k < last) @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [79:0] d;
      logic [95:0] r;
      logic [7:0]  cmds [8];
      cmds = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h80, 8'hFF};
      rst            = 1'b1;
      req_valid      = 1'b0;
      req_cmd        = '0;
      req_arg_num    = '0;
      req_data       = '0;
      req_bad_parity = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_sout", 32'(sout), 1);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(frame_done), 0);
      check_eq("rst_err", 32'(err_arg), 0);
      rst = 1'b0;
      #1;
      check_eq("rst_ready", 32'(req_ready), 1);
      @(negedge clk);

      d = '0;
      d[7:0]  = 8'h0F;
      d[15:8] = 8'hF0;
      run_req(8'h01, 2, d, 1'b0);
      run_req(8'h00, 0, '0, 1'b0);
      run_req(8'h03, 1, '0, 1'b1);
      run_req(8'h02, 11, '1, 1'b0);
      run_req(8'h10, 10, '1, 1'b0);

      // Reset in the middle of arg word 3 of a 5-arg frame.
      req_cmd     = 8'h02;
      req_arg_num = 4'd5;
      req_data    = 80'h0123456789ABCDEF5A5A;
      req_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (39) @(negedge clk);
      check_eq("pre_rst_busy", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_sout", 32'(sout), 1);
      check_eq("midrst_busy", 32'(busy), 0);
      check_eq("midrst_done", 32'(frame_done), 0);
      rst = 1'b0;
      for (int k = 0; k < 80; k++) begin
         #1;
         check_eq($sformatf("post_rst_idle k=%0d", k), 32'({sout, busy, frame_done, req_ready}),
                  32'b1001);
         @(negedge clk);
      end
      run_req(8'h20, 3, 80'h00000000000000332211, 1'b0);

      // Reset and valid together: the request must be dropped.
      rst       = 1'b1;
      req_valid = 1'b1;
      req_arg_num = 4'd0;
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         check_eq($sformatf("rst_wins k=%0d", k), 32'({sout, busy, frame_done}), 32'b100);
         @(negedge clk);
      end

      for (int t = 0; t < 25; t++) begin
         r = {$urandom(), $urandom(), $urandom()};
         run_req(($urandom_range(0, 3) == 0) ? 8'($urandom()) : cmds[$urandom_range(0, 7)],
                 int'($urandom_range(0, 12)), r[79:0], bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
